// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply/divide unit with valid/ready request and response handshakes.
// Shift-add multiply and restoring divide, both retiring one operand bit per clock.
module alu_muldiv #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             div0,
    output logic             err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] OP_MULT = 4'b1110;
    localparam logic [3:0] OP_DIV  = 4'b1111;

    localparam int unsigned   CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             div0_q, div0_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] mul_sum;

    // a_q doubles as the dividend shifter and the quotient accumulator during DIV.
    always_comb begin
        rem_shift = {acc_q, a_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, b_q};
        q_bit     = ~rem_sub[WIDTH];
        mul_sum   = acc_q + (b_q[0] ? a_q : '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        zero_d  = zero_q;
        div0_d  = div0_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d    = A;
                    b_d    = B;
                    acc_d  = '0;
                    cnt_d  = '0;
                    div0_d = 1'b0;
                    err_d  = 1'b0;
                    if (ALUctl == OP_MULT) begin
                        state_d = MUL;
                    end else if (ALUctl == OP_DIV && B != '0) begin
                        state_d = DIV;
                    end else if (ALUctl == OP_DIV) begin
                        state_d = DONE;
                        out_d   = '1;
                        zero_d  = 1'b0;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        out_d   = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = mul_sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = mul_sum;
                    zero_d  = (mul_sum == '0);
                end
            end
            DIV: begin
                acc_d = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d   = a_d;
                    zero_d  = (a_d == '0);
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            div0_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            div0_q  <= div0_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == DONE);
    assign ALUOut     = out_q;
    assign Zero       = zero_q;
    assign div0       = div0_q;
    assign err        = err_q;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, 64, operand and result width in bits.
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  input  1  requester presents an operation.
REQ-005 Port: req_ready  output  1  block can accept an operation.
REQ-006 Port: ALUctl  input  4  operation code: 4'b1110 = MULT, 4'b1111 = DIV, all other codes unsupported.
REQ-007 Port: A  input  WIDTH  first operand (multiplicand or dividend).
REQ-008 Port: B  input  WIDTH  second operand (multiplier or divisor).
REQ-009 Port: resp_valid  output  1  result is available.
REQ-010 Port: resp_ready  input  1  requester consumes the result.
REQ-011 Port: ALUOut  output  WIDTH  result.
REQ-012 Port: Zero  output  1  high when ALUOut equals 0.
REQ-013 Port: div0  output  1  the current result came from a DIV with B = 0.
REQ-014 Port: err  output  1  the current result came from an unsupported ALUctl code.

Function
REQ-015 The block SHALL have four states: IDLE, MUL, DIV and DONE.
REQ-016 req_ready SHALL be high only in IDLE.
REQ-017 An operation SHALL be accepted on a rising edge where req_valid and req_ready are both high.
REQ-018 On acceptance, A, B and ALUctl SHALL be captured; input changes after acceptance SHALL have no effect on the operation in flight.
REQ-019 Accepting ALUctl 1110 SHALL move IDLE to MUL and clear the iteration counter.
REQ-020 Accepting ALUctl 1111 with B != 0 SHALL move IDLE to DIV and clear the iteration counter.
REQ-021 Accepting ALUctl 1111 with B == 0 SHALL move IDLE to DONE with ALUOut = all ones and div0 = 1.
REQ-022 Accepting any other ALUctl code SHALL move IDLE to DONE with ALUOut = 0 and err = 1.
REQ-023 MUL SHALL perform unsigned shift-add, one multiplier bit per cycle, for exactly WIDTH cycles.
REQ-024 MUL SHALL produce the low WIDTH bits of A*B; overflow bits SHALL be discarded.
REQ-025 DIV SHALL perform unsigned restoring division, one quotient bit per cycle, for exactly WIDTH cycles.
REQ-026 DIV SHALL produce the quotient A/B; the remainder SHALL be discarded.
REQ-027 The WIDTH-th iteration edge SHALL move MUL or DIV to DONE.
REQ-028 resp_valid SHALL be first visible WIDTH+1 cycles after the accept edge for MUL or DIV, and 1 cycle after it for the div-by-zero and unsupported cases.
REQ-029 resp_valid SHALL be high only in DONE.
REQ-030 ALUOut, Zero, div0 and err SHALL be registered and SHALL be stable while resp_valid is high.
REQ-031 Zero SHALL equal (ALUOut == 0) whenever resp_valid is high.
REQ-032 A rising edge with resp_valid and resp_ready both high SHALL move DONE to IDLE.
REQ-033 A new request SHALL NOT be accepted on the same edge as a response handshake; the earliest next accept is the following edge.
REQ-034 While resp_ready is low in DONE, the block SHALL hold the result indefinitely.
REQ-035 resp_ready SHALL be ignored outside DONE.
REQ-036 req_valid SHALL be ignored outside IDLE.
REQ-037 Back-to-back MUL throughput SHALL be one result per WIDTH+2 cycles when resp_ready is held high.

Reset
REQ-038 When rst is asserted, the block SHALL enter IDLE immediately, independent of clk, including mid-MUL or mid-DIV; the in-flight operation is discarded.
REQ-039 During reset the outputs SHALL be: req_ready = 1 only after rst deasserts; resp_valid = 0; ALUOut = 0; Zero = 0; div0 = 0; err = 0; iteration counter = 0.
REQ-040 The first request SHALL be accepted on the first rising edge after rst deasserts with req_valid high.

Verification
REQ-041 Basic multiply: MULT, A=3, B=4, resp_ready=1 -> resp_valid rises 65 cycles after accept; ALUOut = 000000000000000C; Zero=0.
REQ-042 Divide, then divide by zero: DIV, A=0xC, B=3 -> ALUOut = 4 after 65 cycles. Then DIV, A=5, B=0 -> resp_valid after 1 cycle; ALUOut = FFFFFFFFFFFFFFFF; div0=1.
REQ-043 Overflow and unsupported code: MULT, A=8000000000000000, B=2 -> ALUOut = 0; Zero=1. Then ALUctl=0000 -> ALUOut = 0; err=1; resp_valid after 1 cycle.
REQ-044 Backpressure: resp_ready held low for 10 cycles after resp_valid -> ALUOut, Zero and resp_valid stay constant and req_ready stays 0. Raising resp_ready -> IDLE on the next edge.
REQ-045 Reset mid-operation: assert rst 30 cycles into a MULT -> resp_valid = 0 and ALUOut = 0 immediately; after release, a DIV with A=100, B=7 returns 14.
REQ-046 Operand isolation: change A and B on every cycle during a MULT with A=5, B=6 -> result is still 1E.
